pong_game_ctrl: RTL

- Parametrised successor to the single-ball VGA bounce game controller.
- Owns ball motion, paddle motion, wall and paddle collision, score and lives counters, and a game state machine (IDLE/PLAY/MISS/OVER).
- Produces the per-pixel colour for the VGA timing block from the current scan coordinates.
- Sits between the key debouncers (one-cycle pulses) and the VGA sync/driver block.

---
 rtl/pong_game_ctrl_if.sv | 26 ++
 rtl/pong_game_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the key debouncers / VGA timing block and pong_game_ctrl.
// The key inputs are single-cycle pulses with no ready/ack: a key is acted on in the one cycle it is high, or it is dropped.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               key_left;
    logic               key_right;
    logic               key_start;
    logic [9:0]         vga_xide;
    logic [9:0]         vga_yide;
    logic [7:0]         vga_data;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic [1:0]         state;
    logic               game_over;

    modport slave (
        input  key_left, key_right, key_start, vga_xide, vga_yide,
        output vga_data, score, lives, state, game_over
    );

    modport master (
        output key_left, key_right, key_start, vga_xide, vga_yide,
        input  vga_data, score, lives, state, game_over
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong controller: ball/paddle motion, collisions, score/lives, game FSM and per-pixel colour.
// Define PONG_SPEEDUP_EN to make the ball speed up by one pixel/tick every 8 paddle hits (max 4).
module pong_game_ctrl #(
    parameter int H_DIS    = 800,
    parameter int V_DIS    = 600,
    parameter int SIDE     = 40,
    parameter int BALL     = 40,
    parameter int PAD_W    = 100,
    parameter int PAD_Y    = 579,
    parameter int PAD_STEP = 20,
    parameter int TICK     = 500000,
    parameter int LIVES    = 3,
    parameter int SCORE_W  = 8,
    parameter int X0       = 100,
    parameter int Y0       = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    pong_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_MISS = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [10:0] SIDE_P   = 11'(SIDE);
    localparam logic [10:0] BALL_P   = 11'(BALL);
    localparam logic [10:0] PAD_W_P  = 11'(PAD_W);
    localparam logic [10:0] PAD_Y_P  = 11'(PAD_Y);
    localparam logic [10:0] STEP_P   = 11'(PAD_STEP);
    localparam logic [10:0] X0_P     = 11'(X0);
    localparam logic [10:0] Y0_P     = 11'(Y0);
    localparam logic [10:0] H_WALL   = 11'(H_DIS - SIDE);
    localparam logic [10:0] V_DIS_P  = 11'(V_DIS);
    localparam logic [10:0] V_MISS   = 11'(V_DIS - 1);
    localparam logic [10:0] PAD_MAX  = 11'(H_DIS - SIDE - PAD_W);
    localparam logic [10:0] PAD_MID  = 11'((H_DIS - PAD_W) / 2);
    localparam logic [3:0]  LIVES_P  = 4'(LIVES);
    localparam int          CNT_W    = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);

    localparam logic [7:0] C_BLUE  = 8'b000_000_11;
    localparam logic [7:0] C_BLACK = 8'h00;
    localparam logic [7:0] C_GREEN = 8'b000_111_00;
    localparam logic [7:0] C_WHITE = 8'hFF;
    localparam logic [7:0] C_RED   = 8'b111_000_00;

    state_t             state_q, state_d;
    logic [10:0]        bx_q, bx_d, by_q, by_d, pad_q, pad_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               move_en;
    logic               pad_hit;
    logic [10:0]        step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign move_en = (cnt_q == CNT_LAST);

`ifdef PONG_SPEEDUP_EN
    logic [2:0] step_q, hit_cnt_q;

    // Held at serve speed for the whole IDLE stay, so every serve starts slow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 3'd1;
            hit_cnt_q <= 3'd0;
        end else if (state_q == S_IDLE) begin
            step_q    <= 3'd1;
            hit_cnt_q <= 3'd0;
        end else if (pad_hit) begin
            hit_cnt_q <= hit_cnt_q + 3'd1;
            if (hit_cnt_q == 3'd7 && step_q < 3'd4) begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    assign step = {8'd0, step_q};
`else
    assign step = 11'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bx_q    <= X0_P;
            by_q    <= Y0_P;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            pad_q   <= PAD_MID;
            score_q <= '0;
            lives_q <= LIVES_P;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            pad_q   <= pad_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        pad_d   = pad_q;
        score_d = score_q;
        lives_d = lives_q;
        pad_hit = 1'b0;

        // Opposite keys in the same cycle cancel out.
        if ((state_q == S_IDLE || state_q == S_PLAY) && (bus.key_left ^ bus.key_right)) begin
            if (bus.key_left) begin
                pad_d = (pad_q >= SIDE_P + STEP_P) ? pad_q - STEP_P : SIDE_P;
            end else begin
                pad_d = (pad_q + STEP_P <= PAD_MAX) ? pad_q + STEP_P : PAD_MAX;
            end
        end

        case (state_q)
            S_IDLE: begin
                bx_d = X0_P;
                by_d = Y0_P;
                dx_d = 1'b1;
                dy_d = 1'b1;
                if (bus.key_start) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (move_en) begin
                    if (!dx_q && bx_q <= SIDE_P) begin
                        dx_d = 1'b1;
                    end else if (dx_q && bx_q + BALL_P >= H_WALL) begin
                        dx_d = 1'b0;
                    end
                    bx_d = dx_d ? bx_q + step : bx_q - step;

                    // Paddle overlap is judged against the already-stepped x.
                    if (!dy_q && by_q <= SIDE_P) begin
                        dy_d = 1'b1;
                    end else if (dy_q && by_q + BALL_P >= PAD_Y_P &&
                                 by_q + BALL_P < PAD_Y_P + step + 11'd1 &&
                                 bx_d + BALL_P > pad_q && bx_d < pad_q + PAD_W_P) begin
                        dy_d    = 1'b0;
                        pad_hit = 1'b1;
                    end
                    by_d = dy_d ? by_q + step : by_q - step;

                    if (dy_d && by_q + BALL_P >= V_MISS) begin
                        bx_d    = bx_q;
                        by_d    = by_q;
                        dx_d    = dx_q;
                        dy_d    = dy_q;
                        state_d = S_MISS;
                    end
                end
            end
            S_MISS: begin
                lives_d = lives_q - 4'd1;
                if (lives_q == 4'd1) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                    bx_d    = X0_P;
                    by_d    = Y0_P;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end
            S_OVER: begin
                if (bus.key_start) begin
                    state_d = S_IDLE;
                    score_d = '0;
                    lives_d = LIVES_P;
                    bx_d    = X0_P;
                    by_d    = Y0_P;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                    pad_d   = PAD_MID;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pad_hit && !(&score_q)) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    logic [10:0] px, py;
    logic        in_wall, in_ball, in_pad;
    logic [7:0]  pix;

    assign px      = {1'b0, bus.vga_xide};
    assign py      = {1'b0, bus.vga_yide};
    assign in_wall = (px < SIDE_P) || (px >= H_WALL) || (py < SIDE_P);
    assign in_ball = (px >= bx_q) && (px < bx_q + BALL_P) && (py >= by_q) && (py < by_q + BALL_P);
    assign in_pad  = (px >= pad_q) && (px < pad_q + PAD_W_P) && (py >= PAD_Y_P) && (py < V_DIS_P);

    always_comb begin
        pix = (state_q == S_OVER) ? C_RED : C_WHITE;
        if (in_pad)  pix = C_GREEN;
        if (in_ball) pix = C_BLACK;
        if (in_wall) pix = C_BLUE;
        if (!rst_n)  pix = C_BLACK;
    end

    assign bus.vga_data  = pix;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.state     = state_q;
    assign bus.game_over = (state_q == S_OVER);
endmodule
